// File: rtl/alu_iter.sv
// Registered EX-stage ALU: single-cycle logic/arith ops plus iterative shift-add
// multiply and restoring divide behind a valid/ready handshake.
module alu_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [3:0]      ALUCtrl_i,
    input  logic [XLEN-1:0] data1_i,
    input  logic [XLEN-1:0] data2_i,
    input  logic            flush_i,
    output logic            valid_o,
    output logic [XLEN-1:0] data_o,
    output logic            Zero_o,
    output logic [1:0]      dbg_state_o
);
    localparam int SHW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_MUL  = 4'h2;
    localparam logic [3:0] OP_XOR  = 4'h3;
    localparam logic [3:0] OP_SLL  = 4'h4;
    localparam logic [3:0] OP_SRA  = 4'h5;
    localparam logic [3:0] OP_AND  = 4'h6;
    localparam logic [3:0] OP_OR   = 4'h7;
    localparam logic [3:0] OP_SRL  = 4'h8;
    localparam logic [3:0] OP_SLT  = 4'h9;
    localparam logic [3:0] OP_SLTU = 4'hA;
    localparam logic [3:0] OP_DIV  = 4'hB;
    localparam logic [3:0] OP_DIVU = 4'hC;
    localparam logic [3:0] OP_REM  = 4'hD;
    localparam logic [3:0] OP_REMU = 4'hE;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    // Handshake: a request transfers on a rising edge where valid_i && ready_o;
    // ready_o depends on state only. valid_o is a one-cycle result pulse.
    state_t          state;
    logic [3:0]      op_r;
    logic [XLEN-1:0] acc;      // product accumulator, or partial remainder
    logic [XLEN-1:0] a_reg;    // multiplier, or dividend shifting into quotient
    logic [XLEN-1:0] b_reg;    // multiplicand, or divisor magnitude
    logic [SHW-1:0]  cnt;
    logic            neg_q;
    logic            neg_r;

    logic [SHW-1:0]  shamt;
    logic            signed_div;
    logic            b_zero;
    logic            ovf;
    logic            is_div_family;
    logic            go_iter;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic [XLEN-1:0] single_res;
    logic [XLEN-1:0] done_res;
    logic [XLEN:0]   rem_sh;
    logic [XLEN:0]   rem_diff;

    assign ready_o     = (state == IDLE);
    assign dbg_state_o = state;

    always_comb begin
        shamt         = data2_i[SHW-1:0];
        signed_div    = (ALUCtrl_i == OP_DIV) || (ALUCtrl_i == OP_REM);
        is_div_family = (ALUCtrl_i == OP_DIV) || (ALUCtrl_i == OP_DIVU) ||
                        (ALUCtrl_i == OP_REM) || (ALUCtrl_i == OP_REMU);
        b_zero        = (data2_i == '0);
        ovf           = signed_div && (data1_i == MIN_VAL) && (data2_i == '1);
        go_iter       = (ALUCtrl_i == OP_MUL) || (is_div_family && !b_zero && !ovf);
        a_mag         = (signed_div && data1_i[XLEN-1]) ? -data1_i : data1_i;
        b_mag         = (signed_div && data2_i[XLEN-1]) ? -data2_i : data2_i;
    end

    // Results registered directly at accept, including the divide special cases.
    always_comb begin
        single_res = '0;
        case (ALUCtrl_i)
            OP_ADD:  single_res = data1_i + data2_i;
            OP_SUB:  single_res = data1_i - data2_i;
            OP_XOR:  single_res = data1_i ^ data2_i;
            OP_SLL:  single_res = data1_i << shamt;
            OP_SRA:  single_res = $signed(data1_i) >>> shamt;
            OP_AND:  single_res = data1_i & data2_i;
            OP_OR:   single_res = data1_i | data2_i;
            OP_SRL:  single_res = data1_i >> shamt;
            OP_SLT:  single_res = {{(XLEN-1){1'b0}}, ($signed(data1_i) < $signed(data2_i))};
            OP_SLTU: single_res = {{(XLEN-1){1'b0}}, (data1_i < data2_i)};
            OP_DIV:  single_res = b_zero ? '1 : data1_i;
            OP_DIVU: single_res = '1;
            OP_REM:  single_res = b_zero ? data1_i : '0;
            OP_REMU: single_res = data1_i;
            default: single_res = '0;
        endcase
    end

    always_comb begin
        rem_sh   = {acc, a_reg[XLEN-1]};
        rem_diff = rem_sh - {1'b0, b_reg};
        done_res = '0;
        case (op_r)
            OP_MUL:  done_res = acc;
            OP_DIV:  done_res = neg_q ? -a_reg : a_reg;
            OP_DIVU: done_res = a_reg;
            OP_REM:  done_res = neg_r ? -acc : acc;
            OP_REMU: done_res = acc;
            default: done_res = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state   <= IDLE;
            op_r    <= '0;
            acc     <= '0;
            a_reg   <= '0;
            b_reg   <= '0;
            cnt     <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            valid_o <= 1'b0;
            data_o  <= '0;
            Zero_o  <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            if (flush_i) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (valid_i && ready_o) begin
                            if (go_iter) begin
                                op_r  <= ALUCtrl_i;
                                acc   <= '0;
                                cnt   <= '0;
                                a_reg <= is_div_family ? a_mag : data1_i;
                                b_reg <= is_div_family ? b_mag : data2_i;
                                neg_q <= (ALUCtrl_i == OP_DIV) && (data1_i[XLEN-1] ^ data2_i[XLEN-1]);
                                neg_r <= (ALUCtrl_i == OP_REM) && data1_i[XLEN-1];
                                state <= (ALUCtrl_i == OP_MUL) ? MUL : DIV;
                            end else begin
                                data_o  <= single_res;
                                Zero_o  <= (single_res == '0);
                                valid_o <= 1'b1;
                            end
                        end
                    end
                    MUL: begin
                        if (a_reg[0]) acc <= acc + b_reg;
                        b_reg <= b_reg << 1;
                        a_reg <= a_reg >> 1;
                        cnt   <= cnt + 1'b1;
                        if (cnt == SHW'(XLEN-1)) state <= DONE;
                    end
                    DIV: begin
                        if (!rem_diff[XLEN]) begin
                            acc   <= rem_diff[XLEN-1:0];
                            a_reg <= {a_reg[XLEN-2:0], 1'b1};
                        end else begin
                            acc   <= rem_sh[XLEN-1:0];
                            a_reg <= {a_reg[XLEN-2:0], 1'b0};
                        end
                        cnt <= cnt + 1'b1;
                        if (cnt == SHW'(XLEN-1)) state <= DONE;
                    end
                    DONE: begin
                        data_o  <= done_res;
                        Zero_o  <= (done_res == '0);
                        valid_o <= 1'b1;
                        cnt     <= '0;
                        state   <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: doc/alu_iter.md
# alu_iter

Parametrised, registered successor to the pipeline's single-cycle EX-stage ALU. It keeps that ALU's 3-bit operation encoding as the low bits of a 4-bit control field and adds OR, SRL, SLT/SLTU and unsigned/signed divide and remainder. It replaces the combinational 32×32 multiply with an iterative shift-add unit. A valid/ready handshake lets the hazard unit stall the pipeline while multi-cycle operations run.

## Interface
- XLEN, 32: operand and result width; legal range 8 to 64.
- SHW, $clog2(XLEN), localparam: shift-amount width.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_n_i  in  1  asynchronous, active-low reset.
- valid_i  in  1  operation request.
- ready_o  out  1  unit can accept a request this cycle.
- ALUCtrl_i  in  4  operation select.
- data1_i  in  XLEN  operand A.
- data2_i  in  XLEN  operand B.
- flush_i  in  1  synchronous abort of the in-flight operation.
- valid_o  out  1  one-cycle pulse; data_o and Zero_o are new.
- data_o  out  XLEN  result, held until the next result.
- Zero_o  out  1  data_o == 0; registered together with data_o.

## Operation
ALUCtrl_i encoding (A = data1_i, B = data2_i):
- 0000 add: A+B.
- 0001 sub: A−B.
- 0010 mul: low XLEN bits of A*B.
- 0011 xor: A^B.
- 0100 sll: A << B[SHW-1:0].
- 0101 sra: arithmetic A >>> B[SHW-1:0].
- 0110 and: A&B.
- 0111 or: A|B.
- 1000 srl: logical A >> B[SHW-1:0].
- 1001 slt: signed A<B, result 1 or 0.
- 1010 sltu: unsigned A<B, result 1 or 0.
- 1011 div: signed A/B.
- 1100 divu: unsigned A/B.
- 1101 rem: signed A%B.
- 1110 remu: unsigned A%B.
- 1111 reserved: result 0.

Rules:
- Add, sub and mul wrap modulo 2^XLEN.
- Signed division truncates toward zero. Remainder sign equals dividend sign.
- Divide by zero: div/divu return all ones; rem/remu return A. This is a single-cycle op.
- Signed overflow (A = −2^(XLEN−1), B = −1): div returns A, rem returns 0. This is a single-cycle op.

FSM:
- IDLE:
  - Accept when valid_i && ready_o.
  - Single-cycle ops and the special cases above register the result immediately.
  - mul goes to MUL. div/divu/rem/remu go to DIV.
  - Operands, op and sign flags are latched into internal registers.
- MUL: one shift-add step per cycle over XLEN steps, then DONE.
- DIV: restoring divide on operand magnitudes, one quotient bit per cycle over XLEN steps, then DONE.
- DONE:
  - Apply sign correction, register data_o/Zero_o, pulse valid_o.
  - Return to IDLE.
- ready_o = (state == IDLE), combinational from state only. It never depends on valid_i.
- Inputs are ignored while ready_o is low.
- flush_i:
  - In any state, flush_i forces IDLE at the next edge.
  - The in-flight result is discarded: no valid_o, data_o unchanged.
  - flush_i together with a valid_i request in IDLE discards that request.
- Reset: state IDLE, ready_o 1, valid_o 0, data_o 0, Zero_o 0, internal counters and accumulators 0.
- Reset asserted mid-operation aborts it with no valid_o after release.

## Timing
- Request accepted at edge E0.
- Single-cycle ops:
  - valid_o high in the cycle after E0, with data_o/Zero_o valid.
  - ready_o stays high, so back-to-back requests are accepted on every edge and produce one valid_o per cycle.
- mul/div/divu/rem/remu:
  - ready_o low from E0 to E(XLEN+1).
  - Iteration steps occur at E1..EXLEN.
  - Result and valid_o are registered at E(XLEN+1), so valid_o is high in the following cycle, concurrently with ready_o high.
  - Total latency XLEN+1 edges: 33 at XLEN=32.
  - A new request may be accepted on the edge ending the valid_o cycle.
- valid_o is never high two cycles for one request.
- data_o is stable outside valid_o pulses.

## Test plan
- Reset and idle: assert rst_n_i low mid-MUL.
  - Required: ready_o=1, valid_o=0, data_o=0, Zero_o=0 immediately.
  - Required: no valid_o after release.
- Single-cycle ops: back-to-back add 7+5, sub 5−5, sra 0x80000000>>>4, slt −1<1.
  - Required: on four consecutive cycles, data_o = 12 / 0 (Zero_o=1) / 0xF8000000 / 1.
- mul 0xFFFFFFFF×3.
  - Required: ready_o low 33 cycles.
  - Required: data_o=0xFFFFFFFD with valid_o exactly 33 cycles after accept.
- Signed division:
  - div −7/2 → 0xFFFFFFFD.
  - rem −7/2 → 0xFFFFFFFF.
  - divu 100/7 → 14.
  - remu 100/7 → 2.
- Special cases:
  - div 0x80000000/−1 → 0x80000000 at latency 1.
  - divu 9/0 → 0xFFFFFFFF.
  - remu 9/0 → 9.
- Flush: flush_i in cycle 10 of a div.
  - Required: IDLE next cycle, no valid_o, data_o unchanged.
  - Required: a following add is accepted immediately.
